// File: rtl/ieeedrv_sd_arbiter_if.sv
// Subdrive request channels and the single host SD block channel of ieeedrv_sd_arbiter.
// Handshake: sd_rd/sd_wr are level requests a drive holds until it sees sd_ack rise;
// host_rd/host_wr stay high until host_ack rises; host_ack then stays high for the whole
// multi-block transfer, and its fall ends the transfer.
interface ieeedrv_sd_arbiter_if #(
    parameter int SUBDRV = 2
);
    logic [SUBDRV-1:0][31:0] sd_lba;
    logic [SUBDRV-1:0][5:0]  sd_blk_cnt;
    logic [SUBDRV-1:0]       sd_rd;
    logic [SUBDRV-1:0]       sd_wr;
    logic [SUBDRV-1:0]       sd_ack;
    logic [31:0]             host_lba;
    logic [5:0]              host_blk_cnt;
    logic                    host_rd;
    logic                    host_wr;
    logic                    host_ack;
    logic [8:0]              host_buff_addr;
    logic                    host_buff_wr;

    modport master (
        input  sd_lba, sd_blk_cnt, sd_rd, sd_wr, host_ack, host_buff_addr, host_buff_wr,
        output sd_ack, host_lba, host_blk_cnt, host_rd, host_wr
    );

    modport slave (
        output sd_lba, sd_blk_cnt, sd_rd, sd_wr, host_ack, host_buff_addr, host_buff_wr,
        input  sd_ack, host_lba, host_blk_cnt, host_rd, host_wr
    );
endinterface

// File: rtl/ieeedrv_sd_arbiter.sv
// Round-robin arbiter of subdrive track requests onto one host SD block channel, with
// track-buffer addressing. Define IEEEDRV_SD_TIMEOUT_EN to add the host_ack timeout.
module ieeedrv_sd_arbiter #(
    parameter int SUBDRV = 2
`ifdef IEEEDRV_SD_TIMEOUT_EN
    ,
    parameter logic [23:0] TIMEOUT_CYC = 24'd12000000
`endif
) (
    input  logic              clk_sys,
    input  logic              reset,
    ieeedrv_sd_arbiter_if.master bus,
    output logic [14:0]       buf_addr,
    output logic [SUBDRV-1:0] buf_wr,
    output logic              grant,
    output logic              busy,
`ifdef IEEEDRV_SD_TIMEOUT_EN
    output logic              timeout_err,
`endif
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_XFER     = 3'd2,
        S_DONE     = 3'd3,
        S_WAIT_LOW = 3'd4,
        S_TOUT     = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              grant_q;
    logic              first_q;
    logic              dir_wr_q;
    logic [31:0]       lba_q;
    logic [5:0]        cnt_q;
    logic [5:0]        blk_idx_q;
    logic [5:0]        blk_cur;
    logic              addr_max_q;
    logic              wrap;
    logic [1:0]        pend2;
    logic [1:0]        wr2;
    logic              start_idx;
    logic              hit;
    logic              hit_idx;
    logic              hit_wr;
    logic [SUBDRV-1:0] grant_oh;
    logic              ack_live;
`ifdef IEEEDRV_SD_TIMEOUT_EN
    logic [23:0]       to_cnt_q;
`endif

    // Scan starts at the drive after the last grant; the first scan after reset starts at 0.
    always_comb begin
        pend2     = 2'(bus.sd_rd | bus.sd_wr);
        wr2       = 2'(bus.sd_wr);
        start_idx = (SUBDRV > 1) && !first_q && !grant_q;
        hit       = 1'b0;
        hit_idx   = 1'b0;
        if (pend2[start_idx]) begin
            hit     = 1'b1;
            hit_idx = start_idx;
        end else if (pend2[!start_idx]) begin
            hit     = 1'b1;
            hit_idx = !start_idx;
        end
        hit_wr = wr2[hit_idx];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (!bus.host_ack && hit) state_d = S_ISSUE;
            S_ISSUE: begin
                if (bus.host_ack) state_d = S_XFER;
`ifdef IEEEDRV_SD_TIMEOUT_EN
                else if (to_cnt_q == TIMEOUT_CYC - 24'd1) state_d = S_TOUT;
`endif
            end
            S_XFER:     if (!bus.host_ack) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            S_WAIT_LOW: if (!bus.host_ack) state_d = S_IDLE;
`ifdef IEEEDRV_SD_TIMEOUT_EN
            S_TOUT:     state_d = S_WAIT_LOW;
`endif
            default:    state_d = S_IDLE;
        endcase
    end

    // The block index steps in the same cycle the byte address wraps, so the first byte
    // of each new block already lands in the right track-buffer slot.
    always_comb begin
        wrap    = (state_q == S_XFER) && addr_max_q && (bus.host_buff_addr == 9'd0);
        blk_cur = blk_idx_q;
        if (wrap && blk_idx_q != 6'd63) blk_cur = blk_idx_q + 6'd1;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            grant_q    <= 1'b0;
            first_q    <= 1'b1;
            dir_wr_q   <= 1'b0;
            lba_q      <= '0;
            cnt_q      <= '0;
            blk_idx_q  <= '0;
            addr_max_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_max_q <= (state_q == S_XFER) && (bus.host_buff_addr == 9'd511);
            if (state_q == S_IDLE && state_d == S_ISSUE) begin
                grant_q  <= hit_idx;
                first_q  <= 1'b0;
                dir_wr_q <= hit_wr;
                lba_q    <= bus.sd_lba[hit_idx];
                cnt_q    <= bus.sd_blk_cnt[hit_idx];
            end
            if (state_q == S_ISSUE) blk_idx_q <= '0;
            else if (state_q == S_XFER) blk_idx_q <= blk_cur;
        end
    end

`ifdef IEEEDRV_SD_TIMEOUT_EN
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            to_cnt_q    <= '0;
            timeout_err <= 1'b0;
        end else begin
            to_cnt_q <= (state_q == S_ISSUE) ? to_cnt_q + 24'd1 : '0;
            if (state_q == S_TOUT) timeout_err <= 1'b1;
        end
    end
`endif

    assign grant_oh         = SUBDRV'(1) << grant_q;
    assign ack_live         = (state_q == S_ISSUE || state_q == S_XFER) && bus.host_ack;
    assign bus.sd_ack       = (ack_live || state_q == S_TOUT) ? grant_oh : '0;
    assign bus.host_rd      = (state_q == S_ISSUE) && !dir_wr_q && !bus.host_ack;
    assign bus.host_wr      = (state_q == S_ISSUE) && dir_wr_q && !bus.host_ack;
    assign bus.host_lba     = lba_q;
    assign bus.host_blk_cnt = cnt_q;
    assign buf_addr         = {blk_cur, bus.host_buff_addr};
    assign buf_wr           = (state_q == S_XFER && bus.host_buff_wr) ? grant_oh : '0;
    assign grant            = grant_q;
    assign busy             = (state_q != S_IDLE);
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_ieeedrv_sd_arbiter.sv
// Bench for ieeedrv_sd_arbiter: requester/host models, request-order reference model and
// a scoreboard checking each host request plus per-transfer buffer traffic.
`timescale 1ns/1ps
module tb_ieeedrv_sd_arbiter;
    localparam int W = 40;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic [14:0] buf_addr;
    logic [1:0]  buf_wr;
    logic        grant;
    logic        busy;
    logic [2:0]  dbg_state;
`ifdef IEEEDRV_SD_TIMEOUT_EN
    logic        timeout_err;
`endif

    ieeedrv_sd_arbiter_if #(.SUBDRV(2)) bus();

    ieeedrv_sd_arbiter #(.SUBDRV(2)) dut (
        .clk_sys  (clk_sys),
        .reset    (rst),
        .bus      (bus),
        .buf_addr (buf_addr),
        .buf_wr   (buf_wr),
        .grant    (grant),
        .busy     (busy),
`ifdef IEEEDRV_SD_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .dbg_state (dbg_state)
    );

    always #5 clk_sys = ~clk_sys;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int           hdrv_q[$];
    int           hblk_q[$];
    int           n_vec = 0;
    int           n_err = 0;
    int           model_last = -1;
    int           force_delay = 0;
    int           spur_req = 0;
    int           spur_done = 0;
    logic         host_busy = 1'b0;

    // requester state
    logic [1:0]   req_rd = '0;
    logic [1:0]   req_wr = '0;
    logic [1:0]   ack_prev = '0;
    logic [31:0]  lba_v [2];
    logic [5:0]   blk_v [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: serve pending drives from the one after the last grant, write before read.
    task automatic plan(input logic [1:0] rd, input logic [1:0] wr);
        logic [1:0] r, w;
        int start, d;
        r = rd;
        w = wr;
        while ((r | w) != 2'b00) begin
            start = (model_last < 0) ? 0 : (model_last + 1) % 2;
            d = (r[start] | w[start]) ? start : 1 - start;
            exp_q.push_back({1'(d), w[d], blk_v[d], lba_v[d]});
            hdrv_q.push_back(d);
            hblk_q.push_back(int'(blk_v[d]) + 1);
            if (w[d]) w[d] = 1'b0;
            else      r[d] = 1'b0;
            model_last = d;
        end
    endtask

    // One clock of the requester model: drop the served request when its ack rises.
    task automatic tick();
        logic [1:0] ack_s;
        @(negedge clk_sys);
        ack_s = bus.sd_ack;
        @(posedge clk_sys);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (ack_s[i] && !ack_prev[i]) begin
                if (req_wr[i]) req_wr[i] = 1'b0;
                else           req_rd[i] = 1'b0;
            end
            bus.sd_lba[i]     = lba_v[i];
            bus.sd_blk_cnt[i] = blk_v[i];
        end
        ack_prev   = ack_s;
        bus.sd_rd  = req_rd;
        bus.sd_wr  = req_wr;
    endtask

    task automatic wait_idle();
        int guard = 0;
        do begin
            tick();
            guard++;
        end while ((exp_q.size() != 0 || host_busy || busy || req_rd != 0 || req_wr != 0)
                   && guard < 40000);
        check("wait_idle_bound", 64'(guard >= 40000), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_host_rd"}, 64'(bus.host_rd), 0);
        check({tag, "_host_wr"}, 64'(bus.host_wr), 0);
        check({tag, "_sd_ack"}, 64'(bus.sd_ack), 0);
        check({tag, "_buf_wr"}, 64'(buf_wr), 0);
        check({tag, "_grant"}, 64'(grant), 0);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_host_lba"}, 64'(bus.host_lba), 0);
        check({tag, "_host_blk_cnt"}, 64'(bus.host_blk_cnt), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        rst = 1'b0;
        model_last = -1;
    endtask

    // Monitor: every new host request is popped against the reference order.
    initial begin
        logic req_now, req_prev;
        logic [W-1:0] e;
        req_prev = 1'b0;
        forever begin
            @(negedge clk_sys);
            req_now = bus.host_rd | bus.host_wr;
            if (req_now && !req_prev) begin
                check("req_while_host_ack", 64'(bus.host_ack), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_request", 64'(req_now), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("request", 64'({grant, bus.host_wr, bus.host_blk_cnt, bus.host_lba}), 64'(e));
                end
            end
            req_prev = req_now;
        end
    end

    // Host model: ack after a delay, stream 512 bytes per block, drop ack.
    initial begin
        int drv, nblk, dly, hi_cnt, total, sent, wr_own, wr_other, ack_bad;
        logic [14:0] last_addr;
        logic [1:0]  oh;
        logic aborted, gap;
        bus.host_ack       = 1'b0;
        bus.host_buff_addr = '0;
        bus.host_buff_wr   = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (spur_req != spur_done) begin
                @(posedge clk_sys); #1;
                bus.host_ack = 1'b1;
                bus.host_buff_wr = 1'b1;
                bus.host_buff_addr = 9'd510;
                repeat (4) begin
                    @(posedge clk_sys); #1;
                    bus.host_buff_addr = bus.host_buff_addr + 9'd1;
                end
                @(posedge clk_sys); #1;
                bus.host_ack = 1'b0;
                bus.host_buff_wr = 1'b0;
                spur_done++;
            end else if ((bus.host_rd || bus.host_wr) && !rst) begin
                host_busy = 1'b1;
                if (hdrv_q.size() == 0) begin
                    check("host_queue_empty", 1, 0);
                    drv = 0;
                    nblk = 1;
                end else begin
                    drv = hdrv_q.pop_front();
                    nblk = hblk_q.pop_front();
                end
                oh = 2'b01 << drv;
                dly = (force_delay != 0) ? force_delay : int'($urandom_range(1, 4));
                hi_cnt = 0;
                for (int k = 0; k < dly; k++) begin
                    if (k > 0) @(negedge clk_sys);
                    if (bus.host_rd || bus.host_wr) hi_cnt++;
                end
                @(posedge clk_sys); #1;
                bus.host_ack = 1'b1;
                bus.host_buff_addr = '0;
                @(negedge clk_sys);
                if (bus.host_rd || bus.host_wr) hi_cnt++;
                check("req_high_cycles", 64'(hi_cnt), 64'(dly));
                check("ack_rise_mirror", 64'(bus.sd_ack), 64'(oh));
                total = nblk * 512;
                sent = 0; wr_own = 0; wr_other = 0; ack_bad = 0;
                last_addr = '0;
                aborted = 1'b0;
                while (sent < total && !aborted) begin
                    @(posedge clk_sys); #1;
                    gap = (total <= 1024) && ($urandom_range(0, 7) == 0);
                    bus.host_buff_wr = !gap;
                    if (!gap) bus.host_buff_addr = 9'(sent % 512);
                    @(negedge clk_sys);
                    if (rst) aborted = 1'b1;
                    else begin
                        if (buf_wr[drv]) wr_own++;
                        if (buf_wr[1 - drv]) wr_other++;
                        if (bus.sd_ack != oh) ack_bad++;
                        if (!gap) begin
                            sent++;
                            last_addr = buf_addr;
                        end
                    end
                end
                @(posedge clk_sys); #1;
                bus.host_buff_wr = 1'b0;
                if (aborted) begin
                    repeat (50) @(posedge clk_sys);
                    #1;
                    bus.host_ack = 1'b0;
                end else begin
                    bus.host_ack = 1'b0;
                    @(negedge clk_sys);
                    check("ack_fall_mirror", 64'(bus.sd_ack), 0);
                    check("buf_wr_granted_count", 64'(wr_own), 64'(total));
                    check("buf_wr_other_count", 64'(wr_other), 0);
                    check("sd_ack_mirror_bad_cycles", 64'(ack_bad), 0);
                    check("buf_addr_last", 64'(last_addr), 64'((nblk - 1) * 512 + 511));
                end
                host_busy = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            lba_v[i] = '0;
            blk_v[i] = '0;
        end
        bus.sd_lba = '0;
        bus.sd_blk_cnt = '0;
        bus.sd_rd = '0;
        bus.sd_wr = '0;
        rst = 1'b1;
        #12;
        check_reset_outputs("reset");
        do_reset();

        // drive 0 read of 29 blocks, host acks 3 cycles later
        force_delay = 3;
        lba_v[0] = 32'h3A;
        blk_v[0] = 6'd28;
        req_rd = 2'b01;
        plan(2'b01, 2'b00);
        wait_idle();
        force_delay = 0;

        // both drives request together right after reset: drive 0 first
        do_reset();
        lba_v[0] = 32'h1000; blk_v[0] = 6'd1;
        lba_v[1] = 32'h2000; blk_v[1] = 6'd0;
        req_rd = 2'b11;
        plan(2'b11, 2'b00);
        wait_idle();

        // drive 1 with read and write high: write first, then read
        lba_v[1] = 32'hBEEF; blk_v[1] = 6'd0;
        req_rd = 2'b10;
        req_wr = 2'b10;
        plan(2'b10, 2'b10);
        wait_idle();

        // spurious host_ack while idle
        spur_req = 1;
        for (int g = 0; g < 20 && spur_done != spur_req; g++) begin
            @(negedge clk_sys);
            check("spur_busy", 64'(busy), 0);
            check("spur_sd_ack", 64'(bus.sd_ack), 0);
            check("spur_buf_wr", 64'(buf_wr), 0);
        end
        check("spur_done", 64'(spur_done), 64'(spur_req));
        tick();

        // reset in the middle of a transfer while host_ack stays high
        lba_v[0] = 32'h55AA; blk_v[0] = 6'd3;
        req_rd = 2'b01;
        plan(2'b01, 2'b00);
        for (int g = 0; g < 50 && !bus.host_ack; g++) tick();
        repeat (100) tick();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midxfer");
        tick();
        rst = 1'b0;
        model_last = -1;
        lba_v[1] = 32'h7777; blk_v[1] = 6'd0;
        req_rd[1] = 1'b1;
        plan(2'b10, 2'b00);
        repeat (10) tick();
        #4;
        check("held_ack_busy", 64'(busy), 0);
        check("held_ack_host_rd", 64'(bus.host_rd), 0);
        wait_idle();

        // randomized request mixes
        for (int s = 0; s < 12; s++) begin
            for (int d = 0; d < 2; d++) begin
                req_rd[d] = 1'($urandom_range(0, 1));
                req_wr[d] = 1'($urandom_range(0, 1));
                lba_v[d]  = $urandom;
                blk_v[d]  = 6'($urandom_range(0, 1));
            end
            if ((req_rd | req_wr) == 2'b00) req_rd[0] = 1'b1;
            plan(req_rd, req_wr);
            wait_idle();
        end

        repeat (5) tick();
        check("exp_q_drained", 64'(exp_q.size()), 0);
        check("host_q_drained", 64'(hdrv_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
